// File: rtl/gyro_loop_checker.sv
// Multi-channel loopback pattern checker: per-channel lock acquisition to an
// incrementing, LFSR or fixed word stream, then word/mismatch counting.
`timescale 1ns/1ps
module gyro_loop_checker #(
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 2,
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [1:0]                  cfg_mode,
    input  logic [DATA_W-1:0]           cfg_seed,
    input  logic                        start,
    input  logic                        stop,
    input  logic [NUM_CH-1:0]           rx_valid,
    input  logic [NUM_CH*DATA_W-1:0]    rx_data,
    output logic [NUM_CH-1:0]           rx_ready,
    output logic [NUM_CH-1:0]           lock,
    output logic [NUM_CH-1:0]           err_flag,
    output logic [NUM_CH*ERR_CNT_W-1:0] err_cnt,
    output logic [NUM_CH*32-1:0]        word_cnt,
    output logic                        irq
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {MODE_INC, MODE_LFSR, MODE_FIXED, MODE_OFF} mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_LOCKED} state_t;

    mode_t             mode_q;
    logic [DATA_W-1:0] seed_q;

    function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w,
                                                    input mode_t m,
                                                    input logic [DATA_W-1:0] s);
        case (m)
            MODE_INC:  return w + DATA_W'(1);
            MODE_LFSR: return {w[DATA_W-2:0], w[DATA_W-1] ^ w[DATA_W-4]};
            default:   return s;
        endcase
    endfunction

    // Pattern configuration is shared by all channels and frozen at start.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mode_q <= MODE_INC;
            seed_q <= '0;
        end else if (start && !stop) begin
            mode_q <= mode_t'(cfg_mode);
            seed_q <= cfg_seed;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t            state;
        logic              have_prev;
        logic [DATA_W-1:0] expv;
        logic [MW-1:0]     match_cnt;
        logic [LW-1:0]     miss_cnt;
        logic [ERR_CNT_W-1:0] errs;
        logic [31:0]       words;
        logic              eflag;

        logic [DATA_W-1:0] word;
        logic              acc;
        logic              hit;
        logic [MW-1:0]     match_nxt;
        logic [LW-1:0]     miss_nxt;
        logic [MW-1:0]     thr;

        assign word      = rx_data[c*DATA_W +: DATA_W];
        assign acc       = rx_valid[c] && (state != ST_IDLE);
        assign hit       = (word == expv);
        assign match_nxt = match_cnt + MW'(1);
        assign miss_nxt  = miss_cnt + LW'(1);
        // Fixed mode counts the seed word itself, so it needs one more match.
        assign thr       = (mode_q == MODE_FIXED) ? MW'(LOCK_CNT) : MW'(LOCK_CNT - 1);

        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                state     <= ST_IDLE;
                have_prev <= 1'b0;
                expv      <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                errs      <= '0;
                words     <= '0;
                eflag     <= 1'b0;
            end else if (stop) begin
                state <= ST_IDLE;
            end else if (start) begin
                if (cfg_mode == MODE_OFF) begin
                    state <= ST_IDLE;
                end else begin
                    state     <= ST_SEEK;
                    have_prev <= 1'b0;
                    match_cnt <= '0;
                    miss_cnt  <= '0;
                    errs      <= '0;
                    words     <= '0;
                    eflag     <= 1'b0;
                end
            end else if (acc) begin
                case (state)
                    ST_SEEK: begin
                        if (!have_prev) begin
                            have_prev <= 1'b1;
                            expv      <= next_word(word, mode_q, seed_q);
                            match_cnt <= (mode_q == MODE_FIXED && word == seed_q) ? MW'(1) : '0;
                        end else begin
                            expv <= next_word(word, mode_q, seed_q);
                            if (!hit) begin
                                match_cnt <= '0;
                            end else if (match_nxt >= thr) begin
                                state     <= ST_LOCKED;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_nxt;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        words <= words + 32'd1;
                        expv  <= next_word(expv, mode_q, seed_q);
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            if (errs != '1) errs <= errs + ERR_CNT_W'(1);
                            eflag <= 1'b1;
                            if (miss_nxt >= LW'(LOSS_CNT)) begin
                                state     <= ST_SEEK;
                                have_prev <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_nxt;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign rx_ready[c]                      = (state != ST_IDLE);
        assign lock[c]                          = (state == ST_LOCKED);
        assign err_flag[c]                      = eflag;
        assign err_cnt[c*ERR_CNT_W +: ERR_CNT_W] = errs;
        assign word_cnt[c*32 +: 32]             = words;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) irq <= 1'b0;
        else          irq <= |err_flag;
    end

endmodule

// File: doc/gyro_loop_checker.md
# gyro_loop_checker

Parametrised, multi-channel loopback pattern checker for the gyro tester PL. It replaces file-based post-simulation comparison of loop/pattern tests with on-line checking. Each channel receives a word stream from a DTX→DRX loop path, acquires lock to an incrementing, LFSR or fixed pattern, then counts words and mismatches. Counters and flags are exported for AXI register mapping and IRQ.

## Interface
- DATA_W, 32, word width; must be ≥ 4.
- NUM_CH, 2, number of independent checker channels; range 1–8.
- ERR_CNT_W, 16, per-channel error counter width.
- LOCK_CNT, 4, number of consecutive matching words needed to lock; must be ≥ 2.
- LOSS_CNT, 8, number of consecutive mismatches in LOCKED that force a return to SEEK.

- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- cfg_mode  in  2  pattern mode: 0 = incrementing, 1 = LFSR, 2 = fixed cfg_seed, 3 = disabled.
- cfg_seed  in  DATA_W  fixed-mode word.
- start  in  1  single-cycle pulse; (re)starts all channels.
- stop  in  1  single-cycle pulse; all channels go to IDLE.
- rx_valid  in  NUM_CH  per-channel word valid.
- rx_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- rx_ready  out  NUM_CH  per-channel accept.
- lock  out  NUM_CH  channel is in LOCKED.
- err_flag  out  NUM_CH  sticky; set by the first counted error since start.
- err_cnt  out  NUM_CH*ERR_CNT_W  saturating mismatch count.
- word_cnt  out  NUM_CH*32  words checked while LOCKED; wraps modulo 2^32.
- irq  out  1  OR of err_flag, registered.

## Operation
- A word is accepted on a cycle where rx_valid[c] & rx_ready[c] = 1.
- rx_ready[c] = 1 in SEEK and LOCKED, 0 in IDLE. Words presented in IDLE are ignored.
- Next-word function f(w):
  - mode 0: f(w) = w+1 mod 2^DATA_W. 0xFFFFFFFF → 0x00000000 is a match.
  - mode 1: f(w) = {w[DATA_W-2:0], w[DATA_W-1]^w[DATA_W-4]}.
  - mode 2: every word must equal cfg_seed.
- cfg_mode and cfg_seed are sampled on start and held internally until the next start.
- Each channel runs its own FSM: IDLE, SEEK, LOCKED.
  - IDLE → SEEK on start, unless sampled mode = 3 (then stays IDLE). Entering SEEK clears lock, err_flag, err_cnt, word_cnt, match_cnt, miss_cnt and the have_prev flag.
  - SEEK:
    - First accepted word stores exp = f(word) (mode 2: exp = cfg_seed; that word counts as a match if equal).
    - Each later word: if word == exp, match_cnt++; otherwise match_cnt = 0. In both cases exp = f(word).
    - match_cnt reaching LOCK_CNT-1 compares after the seed word → LOCKED. For mode 2 the threshold is LOCK_CNT equal words.
    - No errors are counted in SEEK.
  - LOCKED:
    - Each accepted word: word_cnt++; exp advances to f(exp). Exp does not reseed from data, so a single corrupted word produces exactly one error.
    - On mismatch: err_cnt++ saturating at all-ones; err_flag = 1; miss_cnt++.
    - On match: miss_cnt = 0.
    - miss_cnt reaching LOSS_CNT → SEEK with have_prev cleared. err_cnt, err_flag and word_cnt are held, not cleared.
  - Any state → IDLE on stop. Counters and flags hold their values.
- start while in SEEK/LOCKED is a restart: identical to IDLE → SEEK.
- start and stop in the same cycle: stop wins.
- ARESETn low at any time, including mid-stream: all state returns to IDLE and all outputs go to 0 asynchronously.

## Timing
- Reset values: rx_ready = 0, lock = 0, err_flag = 0, err_cnt = 0, word_cnt = 0, irq = 0.
- rx_ready rises 1 cycle after start is sampled and falls 1 cycle after stop.
- Compare result registers on the acceptance edge:
  - lock rises the cycle after the locking word is accepted.
  - err_cnt, err_flag and word_cnt update the cycle after the word is accepted.
  - irq follows err_flag by 1 further cycle.
- Full throughput: one word per channel per cycle, with no back-pressure in active states.
- Channels are fully independent; simultaneous events on different channels never interact.

## Test plan
- Mode 0, ch0: start, then feed 0xFFFFFFFC…0x00000005 back-to-back → lock after the 4th word (0xFFFFFFFF); wrap to 0x00000000 counts no error; final word_cnt = 6, err_cnt = 0.
- Mode 1, seed word 0x00000001, LOCK_CNT = 4: stream 20 LFSR words with word 12 XOR 0x1 → exactly 1 error; err_flag = 1; irq high 2 cycles after that word; lock stays 1.
- Mode 2, cfg_seed = 0xA5A5A5A5: 4 matching words → lock. Then 8 words of 0x0 → err_cnt = 8 and lock drops (LOSS_CNT). Then 4 matching words → relock with err_cnt still 8.
- ERR_CNT_W = 4: 20 mismatches in LOCKED with LOSS_CNT = 32 → err_cnt saturates at 0xF; word_cnt = 20 plus the words accepted before the errors.
- Restart/stop: start mid-LOCKED → counters clear next cycle and the FSM is in SEEK. Start and stop in the same cycle → IDLE with rx_ready = 0. ARESETn low mid-stream → all outputs 0 immediately.
- NUM_CH = 2: ch0 in mode 0 with a clean stream while ch1 receives errors → ch0 err_cnt = 0, ch1 counts correctly, irq asserted from ch1 only.
